// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Instruction-fetch PC sequencer with branch/trap redirects.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        trap,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic [63:0] pc,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [1:0] c_PRIO_NONE   = 2'd0;
    localparam logic [1:0] c_PRIO_BRANCH = 2'd1;
    localparam logic [1:0] c_PRIO_TRAP   = 2'd2;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [63:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_mis, w_mis_nxt;
    logic [1:0]  r_pend_prio, w_pend_prio_nxt;
    logic [63:0] r_pend_tgt, w_pend_tgt_nxt;

    logic        w_bad_align;
    logic [1:0]  w_redir_prio;
    logic [63:0] w_redir_tgt;
    logic        w_redir_mis;
    logic        w_take_new;

    // A misaligned branch keeps branch priority but is steered to the trap vector.
    assign w_bad_align  = (branch_target[1:0] != 2'b00);
    assign w_redir_prio = trap ? c_PRIO_TRAP : (branch_taken ? c_PRIO_BRANCH : c_PRIO_NONE);
    assign w_redir_mis  = !trap && branch_taken && w_bad_align;
    assign w_redir_tgt  = (trap || w_bad_align) ? TRAP_VECTOR : branch_target;
    assign w_take_new   = (w_redir_prio != c_PRIO_NONE) && (w_redir_prio >= r_pend_prio);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_instr     <= 32'h0;
            r_instr_pc  <= 64'h0;
            r_valid     <= 1'b0;
            r_mis       <= 1'b0;
            r_pend_prio <= c_PRIO_NONE;
            r_pend_tgt  <= 64'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_mis       <= w_mis_nxt;
            r_pend_prio <= w_pend_prio_nxt;
            r_pend_tgt  <= w_pend_tgt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_valid_nxt     = r_valid;
        w_mis_nxt       = 1'b0;
        w_pend_prio_nxt = r_pend_prio;
        w_pend_tgt_nxt  = r_pend_tgt;
        unique case (r_state)
            ST_BOOT: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_take_new) begin
                    w_pend_prio_nxt = w_redir_prio;
                    w_pend_tgt_nxt  = w_redir_tgt;
                    w_mis_nxt       = w_redir_mis;
                end
                // Redirect seen on or before the ack discards the fetched word.
                if (imem_ack) begin
                    if (w_pend_prio_nxt != c_PRIO_NONE) begin
                        w_pc_nxt        = w_pend_tgt_nxt;
                        w_pend_prio_nxt = c_PRIO_NONE;
                    end else begin
                        w_instr_nxt    = imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_redir_prio != c_PRIO_NONE) begin
                    w_pc_nxt    = w_redir_tgt;
                    w_mis_nxt   = w_redir_mis;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_FETCH;
                end else if (!stall) begin
                    w_pc_nxt    = r_pc + 64'd4;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign misaligned  = r_mis;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, PC value loaded at reset.
REQ-002 Parameter TRAP_VECTOR, default 64'h100, PC value loaded on trap or misaligned redirect.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 stall  input  1  downstream not ready; holds the issued instruction.
REQ-006 branch_taken  input  1  redirect request; single-cycle pulse.
REQ-007 branch_target  input  64  redirect address, valid with branch_taken.
REQ-008 trap  input  1  exception redirect to TRAP_VECTOR; single-cycle pulse.
REQ-009 imem_req  output  1  instruction-memory fetch request.
REQ-010 imem_addr  output  64  fetch address.
REQ-011 imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 instr_valid  output  1  instr and instr_pc are valid.
REQ-014 instr  output  32  issued instruction.
REQ-015 instr_pc  output  64  address of the issued instruction.
REQ-016 pc  output  64  current PC register value.
REQ-017 misaligned  output  1  one-cycle pulse when a branch_target[1:0] != 0 is rejected.

Function
REQ-018 The FSM SHALL have exactly three states: BOOT, FETCH and ISSUE.
REQ-019 BOOT SHALL last one cycle after reset release, drive imem_req=0, then move to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-021 imem_req and imem_addr SHALL stay stable until imem_ack; a request is never withdrawn.
REQ-022 FETCH with imem_ack and no pending redirect SHALL capture instr<=imem_rdata and instr_pc<=pc, then move to ISSUE with instr_valid=1 on the next cycle.
REQ-023 In ISSUE with stall=1 and no redirect, instr, instr_pc, instr_valid and pc SHALL hold.
REQ-024 In ISSUE with stall=0 and no redirect, pc SHALL become pc+4 (modulo 2^64; wraps to 0), instr_valid SHALL become 0, and the FSM SHALL move to FETCH.
REQ-025 Redirect priority SHALL be trap > branch_taken > sequential.
REQ-026 A redirect in ISSUE SHALL apply regardless of stall: pc<=target, instr_valid<=0, next state FETCH.
REQ-027 A branch_taken with branch_target[1:0] != 0 SHALL redirect to TRAP_VECTOR and pulse misaligned for one cycle.
REQ-028 A redirect in FETCH before imem_ack SHALL be latched as a single pending target; a later redirect overwrites it only if of equal or higher priority.
REQ-029 A redirect arriving in the same cycle as imem_ack SHALL be treated as pending.
REQ-030 On imem_ack with a redirect pending, the fetched word SHALL be discarded (instr_valid stays 0), pc<=pending target, pending cleared, and the FSM SHALL stay in FETCH; the new imem_addr appears the next cycle.
REQ-031 In BOOT, redirects SHALL be ignored.
REQ-032 instr_valid SHALL never be 1 outside ISSUE.

Reset
REQ-033 While reset=0, all flops SHALL clear asynchronously: pc=RESET_VECTOR, state=BOOT, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, misaligned=0, pending cleared.
REQ-034 Reset mid-FETCH SHALL drop the outstanding request; an imem_ack received during BOOT SHALL be ignored.

Verification
REQ-035 Sequential fetch: reset release, ack each request one cycle after it is raised -> imem_addr 0x0, 0x4, 0x8; instr_pc matches each address; instr_valid pulses once per fetch.
REQ-036 Stall: in ISSUE with instr 0x00000013 at pc 0x4, hold stall=1 for 5 cycles -> outputs unchanged and imem_req=0; release stall -> next imem_addr=0x8.
REQ-037 Branch in ISSUE: branch_taken=1, target 0x40, stall=1 -> next imem_addr=0x40 and instr_valid=0.
REQ-038 Redirect mid-fetch: branch to 0x80 while ack delayed 3 cycles -> imem_addr held at old value until ack; fetched word discarded; next imem_addr=0x80.
REQ-039 Priority and misalignment: trap and branch (0x40) in the same cycle -> pc=0x100. Branch to 0x42 -> pc=0x100 and misaligned high for exactly 1 cycle.
REQ-040 Reset mid-operation: pull reset low during FETCH at pc 0x8 -> pc=0, imem_req=0 immediately; after release, BOOT for 1 cycle, then imem_addr=0x0.
